// File: rtl/led_blink_pkg.sv
// Shared types for the multi-channel LED blinker.
// Mode encoding matches the i_Wr_Mode field of the write port.
package led_blink_pkg;

   localparam int unsigned PWM_W = 8;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_PULSE = 2'b11
   } mode_t;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_ON,
      ST_BLINK_HI,
      ST_BLINK_LO,
      ST_PULSE_HI,
      ST_DONE
   } chan_state_t;

endpackage

// File: rtl/led_blink_chan.sv
// One blinker channel: mode FSM, half-period counter and
// shadow/active half-period registers.
module led_blink_chan
   import led_blink_pkg::*;
#(
   parameter int unsigned COUNT_W      = 24,
   parameter int unsigned DEFAULT_HALF = 1250000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [1:0]         wr_mode,
   input  logic [COUNT_W-1:0] wr_half,
   input  logic               sync,
   output logic               led_on
);

   localparam logic [COUNT_W-1:0] RST_HALF = COUNT_W'(DEFAULT_HALF);

   chan_state_t        state_q, state_d;
   mode_t              mode_q, mode_d, wr_mode_e;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic [COUNT_W-1:0] shadow_q, shadow_d;
   logic [COUNT_W-1:0] active_q, active_d;
   logic [COUNT_W-1:0] last_cnt;
   logic               at_end;
   logic               entry;

   assign wr_mode_e = mode_t'(wr_mode);
   // a half-period of 0 behaves like 1
   assign last_cnt  = (active_q == '0) ? '0 : active_q - COUNT_W'(1);
   assign at_end    = cnt_q >= last_cnt;
   assign entry     = wr_en &&
                      (wr_mode_e != mode_q || wr_mode_e == MODE_PULSE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_OFF;
         mode_q   <= MODE_OFF;
         cnt_q    <= '0;
         shadow_q <= RST_HALF;
         active_q <= RST_HALF;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      active_d = active_q;
      if (wr_en) begin
         mode_d   = wr_mode_e;
         shadow_d = wr_half;
      end
      if (entry) begin
         cnt_d    = '0;
         active_d = wr_half;
         unique case (wr_mode_e)
            MODE_OFF:   state_d = ST_OFF;
            MODE_ON:    state_d = ST_ON;
            MODE_BLINK: state_d = ST_BLINK_HI;
            MODE_PULSE: state_d = ST_PULSE_HI;
         endcase
      end else begin
         unique case (state_q)
            ST_BLINK_HI, ST_BLINK_LO: begin
               if (sync) begin
                  cnt_d    = '0;
                  active_d = shadow_d;
                  state_d  = ST_BLINK_HI;
               end else if (at_end) begin
                  cnt_d    = '0;
                  active_d = shadow_q;
                  state_d  = (state_q == ST_BLINK_HI) ?
                             ST_BLINK_LO : ST_BLINK_HI;
               end else begin
                  cnt_d = cnt_q + COUNT_W'(1);
               end
            end
            ST_PULSE_HI: begin
               if (sync) begin
                  cnt_d    = '0;
                  active_d = shadow_d;
               end else if (at_end) begin
                  cnt_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + COUNT_W'(1);
               end
            end
            default: cnt_d = '0;
         endcase
      end
   end

   assign led_on = (state_q == ST_ON) ||
                   (state_q == ST_BLINK_HI) ||
                   (state_q == ST_PULSE_HI);

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker with per-channel mode and half-period.
// Define LED_BLINK_MULTI_PWM_EN for per-channel PWM duty dimming.
module led_blink_multi
   import led_blink_pkg::*;
#(
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned COUNT_W      = 24,
   parameter int unsigned DEFAULT_HALF = 1250000,
   parameter int unsigned CHAN_W       = 2
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   input  logic                i_Wr_En,
   input  logic [CHAN_W-1:0]   i_Wr_Chan,
   input  logic [1:0]          i_Wr_Mode,
   input  logic [COUNT_W-1:0]  i_Wr_Half,
   input  logic                i_Sync,
`ifdef LED_BLINK_MULTI_PWM_EN
   input  logic [PWM_W-1:0]    i_Duty,
`endif
   output logic [CHANNELS-1:0] o_LED
);

   logic [CHANNELS-1:0] wr_sel;
   logic [CHANNELS-1:0] fsm_led;
   logic [CHANNELS-1:0] led_d;

   // out-of-range channel numbers select nothing
   always_comb begin
      wr_sel = '0;
      for (int n = 0; n < CHANNELS; n++) begin
         wr_sel[n] = i_Wr_En && (32'(i_Wr_Chan) == n);
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      led_blink_chan #(
         .COUNT_W      (COUNT_W),
         .DEFAULT_HALF (DEFAULT_HALF)
      ) u_chan (
         .clk     (i_Clk),
         .rst     (i_Rst),
         .wr_en   (wr_sel[g]),
         .wr_mode (i_Wr_Mode),
         .wr_half (i_Wr_Half),
         .sync    (i_Sync),
         .led_on  (fsm_led[g])
      );
   end

`ifdef LED_BLINK_MULTI_PWM_EN
   logic [PWM_W-1:0] pwm_cnt;
   logic [PWM_W-1:0] duty_q [CHANNELS];

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         pwm_cnt <= '0;
         for (int n = 0; n < CHANNELS; n++) duty_q[n] <= '1;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
         for (int n = 0; n < CHANNELS; n++) begin
            if (wr_sel[n]) duty_q[n] <= i_Duty;
         end
      end
   end

   // full-scale duty must never blank, so it bypasses the compare
   always_comb begin
      led_d = '0;
      for (int n = 0; n < CHANNELS; n++) begin
         led_d[n] = fsm_led[n] &&
                    (duty_q[n] == '1 || pwm_cnt < duty_q[n]);
      end
   end
`else
   assign led_d = fsm_led;
`endif

   always_ff @(posedge i_Clk) begin
      if (i_Rst) o_LED <= '0;
      else       o_LED <= led_d;
   end

endmodule

// File: tb/tb_led_blink_multi.sv
// Scoreboard bench for led_blink_multi: stimulus queues expected
// o_LED per cycle, a monitor pops and compares after each edge.
module tb_led_blink_multi;

   localparam int CH = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [1:0]    wr_chan = '0;
   logic [1:0]    wr_mode = '0;
   logic [23:0]   wr_half = '0;
   logic          sync = 1'b0;
   logic [CH-1:0] led;

   typedef struct {
      logic [CH-1:0] mask;
      logic [CH-1:0] val;
      string         name;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_blink_multi #(
      .CHANNELS     (CH),
      .COUNT_W      (24),
      .DEFAULT_HALF (4),
      .CHAN_W       (2)
   ) dut (
      .i_Clk     (clk),
      .i_Rst     (rst),
      .i_Wr_En   (wr_en),
      .i_Wr_Chan (wr_chan),
      .i_Wr_Mode (wr_mode),
      .i_Wr_Half (wr_half),
      .i_Sync    (sync),
`ifdef LED_BLINK_MULTI_PWM_EN
      .i_Duty    (8'hFF),
`endif
      .o_LED     (led)
   );

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (e.mask != '0) begin
            checks++;
            if ((led & e.mask) !== e.val) begin
               errors++;
               $display("FAIL %s: led=%b mask=%b want=%b",
                        e.name, led, e.mask, e.val);
            end
         end
      end
   end

   task automatic tick(input logic [CH-1:0] m,
                       input logic [CH-1:0] v,
                       input string nm);
      exp_t e;
      e.mask = m;
      e.val  = v;
      e.name = nm;
      q.push_back(e);
      @(negedge clk);
      wr_en = 1'b0;
      sync  = 1'b0;
   endtask

   task automatic wr(input logic [1:0] ch, input logic [1:0] md,
                     input logic [23:0] h);
      wr_en   = 1'b1;
      wr_chan = ch;
      wr_mode = md;
      wr_half = h;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick('1, '0, "reset");
      tick('1, '0, "reset");
      rst = 1'b0;
   endtask

   // o_LED at tick j for a blink written at tick s with half h
   function automatic logic bl(int j, int s, int h);
      if (j <= s) return 1'b0;
      return ((j - s - 1) / h) % 2 == 0;
   endfunction

   initial begin
      logic [CH-1:0] v;
      logic          b;
      @(negedge clk);

      // ch0 blink half 4
      do_reset();
      wr(0, 2'b10, 4);
      tick('1, '0, "blink4_w");
      for (int j = 1; j <= 24; j++) begin
         v = '0;
         v[0] = bl(j, 0, 4);
         tick('1, v, "blink4");
      end

      // ch1 half 3, then half 6 mid-phase without mode change
      do_reset();
      wr(1, 2'b10, 3);
      tick('1, '0, "perchg_w");
      for (int j = 1; j <= 24; j++) begin
         if (j == 5) wr(1, 2'b10, 6);
         if (j <= 3)      b = 1'b1;
         else if (j <= 6) b = 1'b0;
         else             b = ((j - 7) / 6) % 2 == 0;
         v = '0;
         v[1] = b;
         tick('1, v, "perchg");
      end

      // ch2 pulse half 5, then retrigger
      do_reset();
      for (int r = 0; r < 2; r++) begin
         wr(2, 2'b11, 5);
         tick('1, '0, "pulse_w");
         for (int j = 1; j <= 15; j++) begin
            v = '0;
            v[2] = (j <= 5);
            tick('1, v, "pulse");
         end
      end

      // ch0 and ch2 offset by 2, aligned by sync
      do_reset();
      wr(0, 2'b10, 4);
      tick('1, '0, "sync_w0");
      for (int j = 1; j <= 30; j++) begin
         if (j == 2)  wr(2, 2'b10, 4);
         if (j == 10) sync = 1'b1;
         v = '0;
         if (j <= 10) begin
            v[0] = bl(j, 0, 4);
            v[2] = bl(j, 2, 4);
         end else begin
            v[0] = bl(j, 10, 4);
            v[2] = v[0];
         end
         tick('1, v, "sync");
      end

      // out-of-range channel ignored; half 0 toggles every clock
      do_reset();
      wr(3, 2'b01, 1);
      tick('1, '0, "badch_w");
      for (int j = 1; j <= 4; j++) tick('1, '0, "badch");
      wr(0, 2'b10, 0);
      tick('1, '0, "half0_w");
      for (int j = 1; j <= 8; j++) begin
         v = '0;
         v[0] = (j % 2) == 1;
         tick('1, v, "half0");
      end

      // reset wins over simultaneous write and sync
      do_reset();
      wr(0, 2'b10, 4);
      tick('1, '0, "rstmid_w");
      for (int j = 1; j <= 5; j++) begin
         v = '0;
         v[0] = bl(j, 0, 4);
         tick('1, v, "rstmid_pre");
      end
      rst  = 1'b1;
      sync = 1'b1;
      wr(1, 2'b01, 2);
      tick('1, '0, "rstmid_rst");
      rst = 1'b0;
      for (int j = 1; j <= 8; j++) tick('1, '0, "rstmid_post");

      for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: left=%0d want=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
